// File: rtl/tama_pkg.sv
// TAMA5 register-window indices and host sequencer encodings, shared with the mapper.
package tama_pkg;

  localparam logic [3:0] IDX_ROM_LO     = 4'h0;
  localparam logic [3:0] IDX_ROM_HI     = 4'h1;
  localparam logic [3:0] IDX_DIN_LO     = 4'h4;
  localparam logic [3:0] IDX_DIN_HI     = 4'h5;
  localparam logic [3:0] IDX_CTRL       = 4'h6;
  localparam logic [3:0] IDX_ADDR_START = 4'h7;
  localparam logic [3:0] IDX_UNLOCK     = 4'hA;
  localparam logic [3:0] IDX_DOUT_LO    = 4'hC;
  localparam logic [3:0] IDX_DOUT_HI    = 4'hD;

  typedef enum logic [3:0] {
    StIdle, StUnlock, StW4, StW5, StW6, StW7, StWait, StRdLo, StRdHi, StDone
  } host_state_e;

  typedef enum logic [1:0] {PhIdle, PhStrobe, PhGap} access_phase_e;

  function automatic logic idx_is_mapped(logic [3:0] idx);
    return idx inside {IDX_ROM_LO, IDX_ROM_HI, IDX_DIN_LO, IDX_DIN_HI, IDX_CTRL,
                       IDX_ADDR_START, IDX_UNLOCK, IDX_DOUT_LO, IDX_DOUT_HI};
  endfunction

endpackage

// File: rtl/tama_host_seq_if.sv
// Host command/response channel plus the $A000/$A001 cartridge register window.
interface tama_host_seq_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_read;
  logic [1:0] cmd_sel;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       bus_a0;
  logic       bus_ncs;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_do;
  logic [7:0] bus_di;

  modport master (
    input  cmd_valid, cmd_read, cmd_sel, cmd_addr, cmd_data, bus_di,
    output cmd_ready, rsp_valid, rsp_data, busy, bus_a0, bus_ncs, bus_wr, bus_rd, bus_do
  );

  modport slave (
    output cmd_valid, cmd_read, cmd_sel, cmd_addr, cmd_data, bus_di,
    input  cmd_ready, rsp_valid, rsp_data, busy, bus_a0, bus_ncs, bus_wr, bus_rd, bus_do
  );

endinterface

// File: rtl/tama_bus_access.sv
// One register-window access: strobe for one ce period, then one ce period of gap.
module tama_bus_access
  import tama_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ce_i,
  input  logic       start_i,
  input  logic       a0_i,
  input  logic       rd_i,
  input  logic [3:0] wdata_i,
  output logic       done_o,
  output logic [3:0] rd_nibble_o,
  input  logic [3:0] bus_di_i,
  output logic       bus_a0_o,
  output logic       bus_ncs_o,
  output logic       bus_wr_o,
  output logic       bus_rd_o,
  output logic [7:0] bus_do_o
);

  access_phase_e phase_q, phase_d;
  logic          a0_q, a0_d, ncs_q, ncs_d, wr_q, wr_d, rd_q, rd_d;
  logic [7:0]    do_q, do_d;

  always_comb begin
    phase_d = phase_q;
    a0_d    = a0_q;
    ncs_d   = ncs_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_d    = do_q;
    if (ce_i) begin
      unique case (phase_q)
        PhStrobe: begin
          phase_d = PhGap;
          ncs_d   = 1'b1;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
        end
        // The gap is the period after the strobe edge; a queued start may strobe again here.
        default: begin
          if (start_i) begin
            phase_d = PhStrobe;
            a0_d    = a0_i;
            do_d    = rd_i ? 8'h00 : {4'h0, wdata_i};
            ncs_d   = 1'b0;
            wr_d    = ~rd_i;
            rd_d    = rd_i;
          end else begin
            phase_d = PhIdle;
          end
        end
      endcase
    end
  end

  assign done_o      = ce_i && (phase_q == PhStrobe);
  assign rd_nibble_o = bus_di_i;
  assign bus_a0_o    = a0_q;
  assign bus_ncs_o   = ncs_q;
  assign bus_wr_o    = wr_q;
  assign bus_rd_o    = rd_q;
  assign bus_do_o    = do_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= PhIdle;
      a0_q    <= 1'b0;
      ncs_q   <= 1'b1;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      do_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      a0_q    <= a0_d;
      ncs_q   <= ncs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      do_q    <= do_d;
    end
  end

endmodule

// File: rtl/tama_host_seq.sv
// TAMA5 initiator: turns one host command into unlock, register writes 4-7 and readback.
module tama_host_seq
  import tama_pkg::*;
#(
  parameter bit          UNLOCK_EVERY_CMD = 1'b0,
  parameter int unsigned RD_WAIT          = 2
) (
  input logic             clk_sys,
  input logic             reset,
  input logic             ce_cpu,
  tama_host_seq_if.master hs
);

  host_state_e state_q, state_d;
  logic        step_q, step_d, unlocked_q, unlocked_d, read_q, read_d;
  logic [1:0]  sel_q, sel_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d, wait_q, wait_d, rsp_data_q, rsp_data_d;
  logic [3:0]  rd_lo_q, rd_lo_d, reg_idx, reg_val, acc_wdata, acc_nibble;
  logic        acc_start, acc_a0, acc_rd, acc_done;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    unlocked_d = unlocked_q;
    read_d     = read_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wait_d     = wait_q;
    rd_lo_d    = rd_lo_q;
    rsp_data_d = rsp_data_q;
    acc_start  = 1'b0;
    acc_a0     = 1'b1;
    acc_rd     = 1'b0;
    acc_wdata  = 4'h0;
    reg_idx    = IDX_DIN_LO;
    reg_val    = data_q[3:0];
    unique case (state_q)
      StW5:    begin reg_idx = IDX_DIN_HI;     reg_val = data_q[7:4]; end
      StW6:    begin reg_idx = IDX_CTRL;       reg_val = {sel_q, read_q, addr_q[4]}; end
      StW7:    begin reg_idx = IDX_ADDR_START; reg_val = addr_q[3:0]; end
      default: ;
    endcase

    // step_q selects the half of a pair: 0 = index to $A001, 1 = data at $A000.
    unique case (state_q)
      StIdle: begin
        if (hs.cmd_valid) begin
          read_d  = hs.cmd_read;
          sel_d   = hs.cmd_sel;
          addr_d  = hs.cmd_addr;
          data_d  = hs.cmd_data;
          step_d  = 1'b0;
          state_d = (!unlocked_q || UNLOCK_EVERY_CMD) ? StUnlock : StW4;
        end
      end
      StUnlock: begin
        acc_start = 1'b1;
        acc_wdata = IDX_UNLOCK;
        if (acc_done) begin
          unlocked_d = 1'b1;
          state_d    = StW4;
        end
      end
      StW4, StW5, StW6, StW7: begin
        acc_start = 1'b1;
        acc_a0    = ~step_q;
        acc_wdata = step_q ? reg_val : reg_idx;
        if (acc_done) begin
          step_d = ~step_q;
          if (step_q) begin
            unique case (state_q)
              StW4:    state_d = StW5;
              StW5:    state_d = StW6;
              StW6:    state_d = StW7;
              default: begin
                wait_d  = 8'h00;
                state_d = read_q ? StWait : StDone;
              end
            endcase
          end
        end
      end
      StWait: begin
        if (ce_cpu) begin
          wait_d = wait_q + 8'd1;
          if (wait_q == 8'(RD_WAIT - 1)) state_d = StRdLo;
        end
      end
      StRdLo, StRdHi: begin
        acc_start = 1'b1;
        acc_a0    = ~step_q;
        acc_rd    = step_q;
        acc_wdata = (state_q == StRdLo) ? IDX_DOUT_LO : IDX_DOUT_HI;
        if (acc_done) begin
          step_d = ~step_q;
          if (step_q && state_q == StRdLo) begin
            rd_lo_d = acc_nibble;
            state_d = StRdHi;
          end else if (step_q) begin
            rsp_data_d = {acc_nibble, rd_lo_q};
            state_d    = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign hs.cmd_ready = (state_q == StIdle);
  assign hs.busy      = (state_q != StIdle);
  assign hs.rsp_valid = (state_q == StDone) && read_q;
  assign hs.rsp_data  = rsp_data_q;

  tama_bus_access u_access (
    .clk_i       (clk_sys),
    .reset_i     (reset),
    .ce_i        (ce_cpu),
    .start_i     (acc_start),
    .a0_i        (acc_a0),
    .rd_i        (acc_rd),
    .wdata_i     (acc_wdata),
    .done_o      (acc_done),
    .rd_nibble_o (acc_nibble),
    .bus_di_i    (hs.bus_di[3:0]),
    .bus_a0_o    (hs.bus_a0),
    .bus_ncs_o   (hs.bus_ncs),
    .bus_wr_o    (hs.bus_wr),
    .bus_rd_o    (hs.bus_rd),
    .bus_do_o    (hs.bus_do)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      step_q     <= 1'b0;
      unlocked_q <= 1'b0;
      read_q     <= 1'b0;
      sel_q      <= 2'd0;
      addr_q     <= 5'd0;
      data_q     <= 8'h00;
      wait_q     <= 8'h00;
      rd_lo_q    <= 4'h0;
      rsp_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      unlocked_q <= unlocked_d;
      read_q     <= read_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wait_q     <= wait_d;
      rd_lo_q    <= rd_lo_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_tama_host_seq.sv
// Bench for tama_host_seq: mapper model on the register window, access-log reference, RAM model.
module tb_tama_host_seq;
  import tama_pkg::*;

  logic clk_sys = 1'b0;
  logic reset;
  logic ce_cpu;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ce_mode = 0;
  int   ce_div = 0;

  tama_host_seq_if hs ();

  tama_host_seq #(
    .UNLOCK_EVERY_CMD (1'b0),
    .RD_WAIT          (2)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_cpu  (ce_cpu),
    .hs      (hs)
  );

  always #5 clk_sys = ~clk_sys;

  // ce_cpu pattern: 0 = every cycle, 1 = every 4th cycle, 2 = random
  initial begin
    ce_cpu = 1'b1;
    forever begin
      @(negedge clk_sys);
      ce_div = (ce_div + 1) % 4;
      case (ce_mode)
        0:       ce_cpu = 1'b1;
        1:       ce_cpu = (ce_div == 0);
        default: ce_cpu = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Mapper model and access monitor; log entry = {a0, is_read, write data}.
  logic [9:0] acc_log[$];
  int         len_log[$];
  logic [3:0] map_idx;
  logic [3:0] map_reg [16];
  logic [7:0] map_ram [32];
  logic [7:0] map_dout, rtc_min, rtc_sec;
  logic       prev_stb = 1'b0;
  int         stb_len = 0;
  logic [1:0] m_sel;
  logic       m_rd;
  logic [4:0] m_addr;
  logic [7:0] m_wdata;

  assign m_sel     = map_reg[IDX_CTRL][3:2];
  assign m_rd      = map_reg[IDX_CTRL][1];
  assign m_addr    = {map_reg[IDX_CTRL][0], hs.bus_do[3:0]};
  assign m_wdata   = {map_reg[IDX_DIN_HI], map_reg[IDX_DIN_LO]};
  assign hs.bus_di = {4'h5, (map_idx == IDX_DOUT_HI) ? map_dout[7:4] : map_dout[3:0]};

  always @(negedge clk_sys) begin
    prev_stb <= hs.bus_wr | hs.bus_rd;
    if ((hs.bus_wr | hs.bus_rd) && !prev_stb) begin
      acc_log.push_back({hs.bus_a0, hs.bus_rd, hs.bus_rd ? 8'h00 : hs.bus_do});
      if (hs.bus_wr && hs.bus_a0) begin
        map_idx <= hs.bus_do[3:0];
      end else if (hs.bus_wr && idx_is_mapped(map_idx)) begin
        map_reg[map_idx] <= hs.bus_do[3:0];
        if (map_idx == IDX_ADDR_START) begin
          if (m_sel == 2'd0 && m_rd) map_dout <= map_ram[m_addr];
          else if (m_sel == 2'd0) map_ram[m_addr] <= m_wdata;
          else if (m_sel == 2'd1 && !m_rd && m_addr == 5'h04) begin
            rtc_min <= m_wdata;
            rtc_sec <= 8'h00;
          end
        end
      end
    end
    if (hs.bus_wr | hs.bus_rd) begin
      stb_len <= stb_len + 1;
    end else if (prev_stb) begin
      len_log.push_back(stb_len);
      stb_len <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected register-window traffic for one command.
  task automatic check_log(input string tag, input bit unl, input bit rd, input logic [1:0] sel,
                           input logic [4:0] addr, input logic [7:0] data);
    logic [9:0] exp[$];
    if (unl) exp.push_back({2'b10, 8'h0A});
    exp.push_back({2'b10, 8'h04}); exp.push_back({2'b00, 4'h0, data[3:0]});
    exp.push_back({2'b10, 8'h05}); exp.push_back({2'b00, 4'h0, data[7:4]});
    exp.push_back({2'b10, 8'h06}); exp.push_back({2'b00, 4'h0, sel, rd, addr[4]});
    exp.push_back({2'b10, 8'h07}); exp.push_back({2'b00, 4'h0, addr[3:0]});
    if (rd) begin
      exp.push_back({2'b10, 8'h0C}); exp.push_back({2'b01, 8'h00});
      exp.push_back({2'b10, 8'h0D}); exp.push_back({2'b01, 8'h00});
    end
    chk({tag, "_log_len"}, acc_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < acc_log.size(); i++)
      chk($sformatf("%s_acc%0d", tag, i), 32'(acc_log[i]), 32'(exp[i]));
  endtask

  task automatic issue(input bit rd, input logic [1:0] sel, input logic [4:0] addr,
                       input logic [7:0] data, input bit hold);
    int t = 0;
    while (!hs.cmd_ready && t < 500) begin
      @(negedge clk_sys);
      t++;
    end
    if (!hs.cmd_ready) chk("issue_ready_timeout", 32'(hs.cmd_ready), 1);
    hs.cmd_valid = 1'b1;
    hs.cmd_read  = rd;
    hs.cmd_sel   = sel;
    hs.cmd_addr  = addr;
    hs.cmd_data  = data;
    @(negedge clk_sys);
    if (!hold) hs.cmd_valid = 1'b0;
  endtask

  // Cycle 0 is the first negedge after the accepting edge.
  task automatic finish_cmd(output int lat_ready, output int lat_rsp, output int n_rsp,
                            output logic [7:0] rsp);
    int cyc = 0;
    lat_ready = -1;
    lat_rsp   = -1;
    n_rsp     = 0;
    rsp       = 8'h00;
    while (cyc < 4000) begin
      if (hs.rsp_valid) begin
        n_rsp++;
        lat_rsp = cyc;
        rsp     = hs.rsp_data;
      end
      if (hs.cmd_ready) begin
        lat_ready    = cyc;
        hs.cmd_valid = 1'b0;
        break;
      end
      @(negedge clk_sys);
      cyc++;
    end
    if (lat_ready < 0) chk("finish_timeout", 32'(hs.cmd_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         lat_r, lat_s, n_r, t;
    logic [7:0] rsp;
    logic [7:0] ref_ram [32];
    logic [4:0] written[$];
    bit         unl_ref;
    bit         rd;
    logic [4:0] addr;
    logic [7:0] data;

    hs.cmd_valid = 1'b0; hs.cmd_read = 1'b0; hs.cmd_sel = 2'd0;
    hs.cmd_addr = 5'd0; hs.cmd_data = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_cmd_ready", 32'(hs.cmd_ready), 1);
    chk("rst_busy", 32'(hs.busy), 0);
    chk("rst_rsp_valid", 32'(hs.rsp_valid), 0);
    chk("rst_rsp_data", 32'(hs.rsp_data), 0);
    chk("rst_bus_a0", 32'(hs.bus_a0), 0);
    chk("rst_bus_ncs", 32'(hs.bus_ncs), 1);
    chk("rst_bus_wr", 32'(hs.bus_wr), 0);
    chk("rst_bus_rd", 32'(hs.bus_rd), 0);
    chk("rst_bus_do", 32'(hs.bus_do), 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // First write after reset, unlock included
    acc_log.delete(); len_log.delete();
    issue(1'b0, 2'd0, 5'h05, 8'h3C, 1'b0);
    chk("wr1_busy", 32'(hs.busy), 1);
    finish_cmd(lat_r, lat_s, n_r, rsp);
    check_log("wr1", 1'b1, 1'b0, 2'd0, 5'h05, 8'h3C);
    chk("wr1_ready_lat", 32'(lat_r), 19);
    chk("wr1_no_rsp", 32'(n_r), 0);
    chk("wr1_ram", 32'(map_ram[5]), 32'h3C);
    ref_ram[5] = 8'h3C; written.push_back(5'h05); unl_ref = 1'b1;

    // Readback, no unlock
    acc_log.delete();
    issue(1'b1, 2'd0, 5'h05, 8'h00, 1'b0);
    finish_cmd(lat_r, lat_s, n_r, rsp);
    check_log("rd1", 1'b0, 1'b1, 2'd0, 5'h05, 8'h00);
    chk("rd1_rsp", 32'(rsp), 32'h3C);
    chk("rd1_rsp_lat", 32'(lat_s), 26);
    chk("rd1_pulses", 32'(n_r), 1);
    chk("rd1_ready_lat", 32'(lat_r), 27);
    @(negedge clk_sys);
    chk("rd1_rsp_hold", 32'(hs.rsp_data), 32'h3C);

    // RTC page write
    acc_log.delete();
    issue(1'b0, 2'd1, 5'h04, 8'h27, 1'b0);
    finish_cmd(lat_r, lat_s, n_r, rsp);
    check_log("rtc", 1'b0, 1'b0, 2'd1, 5'h04, 8'h27);
    chk("rtc_min", 32'(rtc_min), 32'h27);
    chk("rtc_sec", 32'(rtc_sec), 0);

    // Quarter-rate ce: every strobe spans four clocks
    ce_mode = 1;
    acc_log.delete(); len_log.delete();
    issue(1'b0, 2'd0, 5'h1A, 8'hB7, 1'b0);
    finish_cmd(lat_r, lat_s, n_r, rsp);
    check_log("slow", 1'b0, 1'b0, 2'd0, 5'h1A, 8'hB7);
    chk("slow_strobes", 32'(len_log.size()), 8);
    for (int i = 0; i < len_log.size(); i++) chk($sformatf("slow_len%0d", i), 32'(len_log[i]), 4);
    chk("slow_ram", 32'(map_ram[26]), 32'hB7);
    ref_ram[26] = 8'hB7; written.push_back(5'h1A);
    ce_mode = 0;
    @(negedge clk_sys);

    // Reset while the reg-6 index strobe is on the bus
    issue(1'b0, 2'd0, 5'h09, 8'h44, 1'b0);
    t = 0;
    while (!(hs.bus_wr && hs.bus_a0 && hs.bus_do == 8'h06) && t < 200) begin
      @(negedge clk_sys);
      t++;
    end
    chk("w6_seen", 32'(hs.bus_wr && hs.bus_a0 && hs.bus_do == 8'h06), 1);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("midrst_wr", 32'(hs.bus_wr), 0);
    chk("midrst_ncs", 32'(hs.bus_ncs), 1);
    chk("midrst_ready", 32'(hs.cmd_ready), 1);
    @(negedge clk_sys);
    hs.cmd_valid = 1'b1; hs.cmd_read = 1'b0; hs.cmd_addr = 5'h0F; hs.cmd_data = 8'hEE;
    @(negedge clk_sys);
    chk("rst_valid_dropped", 32'(hs.cmd_ready), 1);
    hs.cmd_valid = 1'b0;
    reset = 1'b0;
    unl_ref = 1'b0;
    @(negedge clk_sys);
    acc_log.delete();
    issue(1'b0, 2'd0, 5'h11, 8'h5A, 1'b0);
    finish_cmd(lat_r, lat_s, n_r, rsp);
    check_log("post_rst", 1'b1, 1'b0, 2'd0, 5'h11, 8'h5A);
    ref_ram[17] = 8'h5A; written.push_back(5'h11); unl_ref = 1'b1;

    // cmd_valid held through busy: one command per ready window
    acc_log.delete();
    issue(1'b0, 2'd0, 5'h02, 8'h99, 1'b1);
    finish_cmd(lat_r, lat_s, n_r, rsp);
    repeat (6) @(negedge clk_sys);
    chk("hold_ready", 32'(hs.cmd_ready), 1);
    check_log("hold", 1'b0, 1'b0, 2'd0, 5'h02, 8'h99);
    ref_ram[2] = 8'h99; written.push_back(5'h02);

    // Random reads/writes under random ce
    ce_mode = 2;
    for (int n = 0; n < 24; n++) begin
      rd   = ($urandom_range(0, 2) == 0);
      addr = rd ? written[$urandom_range(0, written.size() - 1)] : 5'($urandom_range(0, 31));
      data = 8'($urandom);
      acc_log.delete();
      issue(rd, 2'd0, addr, data, 1'b0);
      finish_cmd(lat_r, lat_s, n_r, rsp);
      check_log($sformatf("rnd%0d", n), !unl_ref, rd, 2'd0, addr, data);
      if (rd) begin
        chk($sformatf("rnd%0d_rsp", n), 32'(rsp), 32'(ref_ram[addr]));
        chk($sformatf("rnd%0d_pulses", n), 32'(n_r), 1);
      end else begin
        ref_ram[addr] = data;
        written.push_back(addr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
